// File: rtl/alu_flags_pkg.sv
// Shared constants and types for the ALU flag register: flag bit positions,
// branch condition codes and the MainBus word layout.
package alu_flags_pkg;

  localparam int unsigned FLAG_W     = 5;
  localparam int unsigned BUS_W      = 8;
  localparam int unsigned BUS_PAD_W  = BUS_W - FLAG_W;
  localparam int unsigned COND_W     = 4;
  localparam int unsigned COND_SRC_W = 3;

  localparam int unsigned FLAG_OV = 0;
  localparam int unsigned FLAG_S  = 1;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_CA = 3;
  localparam int unsigned FLAG_CL = 4;

  localparam logic [COND_SRC_W-1:0] COND_ALWAYS = 3'd0;
  localparam logic [COND_SRC_W-1:0] COND_EQ     = 3'd1;
  localparam logic [COND_SRC_W-1:0] COND_CS     = 3'd2;
  localparam logic [COND_SRC_W-1:0] COND_MI     = 3'd3;
  localparam logic [COND_SRC_W-1:0] COND_VS     = 3'd4;
  localparam logic [COND_SRC_W-1:0] COND_LC     = 3'd5;
  localparam logic [COND_SRC_W-1:0] COND_LT     = 3'd6;
  localparam logic [COND_SRC_W-1:0] COND_ULE    = 3'd7;
  localparam int unsigned           COND_INV    = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  // MainBus image of the flag register: upper bits are always zero on drive
  typedef struct packed {
    logic [BUS_PAD_W-1:0] pad;
    flags_t               flags;
  } bus_word_t;

  function automatic flags_t mask_merge(input flags_t old_f, input flags_t new_f,
                                        input flags_t mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch-condition mux with optional inversion.
module alu_cond_eval
  import alu_flags_pkg::*;
(
  input  flags_t            i_flags,
  input  logic [COND_W-1:0] i_sel,
  output logic              o_true_c
);

  logic w_src;

  always_comb begin
    w_src = 1'b1;
    case (i_sel[COND_SRC_W-1:0])
      COND_ALWAYS: w_src = 1'b1;
      COND_EQ:     w_src = i_flags[FLAG_Z];
      COND_CS:     w_src = i_flags[FLAG_CA];
      COND_MI:     w_src = i_flags[FLAG_S];
      COND_VS:     w_src = i_flags[FLAG_OV];
      COND_LC:     w_src = i_flags[FLAG_CL];
      COND_LT:     w_src = i_flags[FLAG_S] ^ i_flags[FLAG_OV];
      COND_ULE:    w_src = i_flags[FLAG_CA] | i_flags[FLAG_Z];
    endcase
    o_true_c = w_src ^ i_sel[COND_INV];
  end

endmodule

// File: rtl/alu_flags_register.sv
// ALU flag register: masked capture, MainBus save/restore, carry feedback and
// registered branch-condition evaluation on the forwarded next flag value.
module alu_flags_register
  import alu_flags_pkg::*;
#(
  parameter int unsigned           FLAG_WIDTH  = 5,
  parameter int unsigned           BUS_WIDTH   = 8,
  parameter logic [FLAG_WIDTH-1:0] RESET_FLAGS = 5'b00000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flags_0_Overflow,
  input  logic                  Flags_1_Sign,
  input  logic                  Flags_2_Zero,
  input  logic                  Flags_3_CarryA,
  input  logic                  Flags_4_CarryL,
  input  logic                  AluActive,
  input  logic [FLAG_WIDTH-1:0] Update_Mask,
  inout  tri   [BUS_WIDTH-1:0]  MainBus,
  input  logic                  Flags_Assert,
  input  logic                  Flags_Load,
  input  logic                  Cond_Eval,
  input  logic [COND_W-1:0]     Cond_Select,
  output logic [FLAG_WIDTH-1:0] Flags,
  output logic                  LCarryIn,
  output logic                  Cond_Valid,
  output logic                  Cond_True
);

  flags_t    r_flags;
  logic      r_lcarry;
  logic      r_cond_valid;
  logic      r_cond_true;

  flags_t    w_alu_flags;
  flags_t    w_flags_next;
  bus_word_t w_bus_in;
  bus_word_t w_bus_out;
  logic      w_bus_drive;
  logic      w_bus_load;
  logic      w_cond_true_c;
  logic      w_unused_bus;

  always_comb begin
    w_alu_flags          = '0;
    w_alu_flags[FLAG_OV] = Flags_0_Overflow;
    w_alu_flags[FLAG_S]  = Flags_1_Sign;
    w_alu_flags[FLAG_Z]  = Flags_2_Zero;
    w_alu_flags[FLAG_CA] = Flags_3_CarryA;
    w_alu_flags[FLAG_CL] = Flags_4_CarryL;
  end

  // A load is suppressed while we are driving the bus ourselves
  assign w_bus_drive = ~Flags_Assert & ~Reset;
  assign w_bus_load  = ~Flags_Load & Flags_Assert;

  assign w_bus_out.pad   = '0;
  assign w_bus_out.flags = r_flags;
  assign MainBus         = w_bus_drive ? w_bus_out : {BUS_WIDTH{1'bz}};
  assign w_bus_in        = MainBus;
  assign w_unused_bus    = ^w_bus_in.pad;

  always_comb begin
    w_flags_next = r_flags;
    if (w_bus_load) begin
      w_flags_next = w_bus_in.flags;
    end else if (AluActive) begin
      w_flags_next = mask_merge(r_flags, w_alu_flags, Update_Mask);
    end
  end

  alu_cond_eval u_cond_eval (
    .i_flags  (w_flags_next),
    .i_sel    (Cond_Select),
    .o_true_c (w_cond_true_c)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_flags      <= RESET_FLAGS;
      r_lcarry     <= RESET_FLAGS[FLAG_CL];
      r_cond_valid <= 1'b0;
      r_cond_true  <= 1'b0;
    end else begin
      r_flags      <= w_flags_next;
      r_lcarry     <= w_flags_next[FLAG_CL];
      r_cond_valid <= Cond_Eval;
      if (Cond_Eval) begin
        r_cond_true <= w_cond_true_c;
      end
    end
  end

  assign Flags      = r_flags;
  assign LCarryIn   = r_lcarry;
  assign Cond_Valid = r_cond_valid;
  assign Cond_True  = r_cond_true;

endmodule

// File: tb/tb_alu_flags_register.sv
// Self-checking bench: directed cases with literal expectations plus random
// stimulus compared each cycle against a behavioural flag/condition model.
module tb_alu_flags_register;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] alu;      // {CL, CA, Z, S, OV}
  logic       alu_active;
  logic [4:0] mask;
  logic       assert_n;
  logic       load_n;
  logic       cond_eval;
  logic [3:0] cond_sel;
  logic [7:0] tb_bus_val;
  logic       tb_bus_en;
  tri   [7:0] main_bus;

  logic [4:0] flags;
  logic       lcarry;
  logic       cond_valid;
  logic       cond_true;

  logic [4:0] m_flags;
  logic       m_valid;
  logic       m_true;
  logic       chk_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  assign main_bus = tb_bus_en ? tb_bus_val : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  alu_flags_register dut (
    .Clock            (clk),
    .Reset            (reset),
    .Flags_0_Overflow (alu[0]),
    .Flags_1_Sign     (alu[1]),
    .Flags_2_Zero     (alu[2]),
    .Flags_3_CarryA   (alu[3]),
    .Flags_4_CarryL   (alu[4]),
    .AluActive        (alu_active),
    .Update_Mask      (mask),
    .MainBus          (main_bus),
    .Flags_Assert     (assert_n),
    .Flags_Load       (load_n),
    .Cond_Eval        (cond_eval),
    .Cond_Select      (cond_sel),
    .Flags            (flags),
    .LCarryIn         (lcarry),
    .Cond_Valid       (cond_valid),
    .Cond_True        (cond_true)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Condition truth table stated by flag name
  function automatic logic cond_of(input logic [4:0] f, input logic [3:0] sel);
    logic ov, s, z, ca, cl, r;
    {cl, ca, z, s, ov} = f;
    case (sel[2:0])
      3'd0:    r = 1'b1;
      3'd1:    r = z;
      3'd2:    r = ca;
      3'd3:    r = s;
      3'd4:    r = ov;
      3'd5:    r = cl;
      3'd6:    r = (s != ov);
      default: r = ca || z;
    endcase
    return sel[3] ? !r : r;
  endfunction

  // Reference model, advanced on each rising edge from the inputs applied
  always @(posedge clk) begin
    logic [4:0] nf;
    if (reset) begin
      m_flags = 5'b00000;
      m_valid = 1'b0;
      m_true  = 1'b0;
    end else begin
      nf = m_flags;
      if (!load_n && assert_n) nf = tb_bus_val[4:0];
      else if (alu_active)
        for (int i = 0; i < 5; i++) if (mask[i]) nf[i] = alu[i];
      m_valid = cond_eval;
      if (cond_eval) m_true = cond_of(nf, cond_sel);
      m_flags = nf;
    end
  end

  // Per-cycle compare of registered outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("flags", {3'b000, flags}, {3'b000, m_flags});
      chk("lcarry", {7'd0, lcarry}, {7'd0, m_flags[4]});
      chk("cond_valid", {7'd0, cond_valid}, {7'd0, m_valid});
      chk("cond_true", {7'd0, cond_true}, {7'd0, m_true});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    reset = 1'b0; alu_active = 1'b0; mask = 5'd0; alu = 5'd0;
    assert_n = 1'b1; load_n = 1'b1; cond_eval = 1'b0; cond_sel = 4'd0;
    tb_bus_en = 1'b0; tb_bus_val = 8'd0;
  endtask

  task automatic capture(input logic [4:0] f);
    idle();
    alu_active = 1'b1; mask = 5'b11111; alu = f;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    // Bus must stay released during reset even with Flags_Assert low
    assert_n = 1'b0; tb_bus_en = 1'b1; tb_bus_val = 8'h5A;
    tick();
    #1 chk("bus_rel_reset", main_bus, 8'h5A);
    chk("rst_flags", {3'b000, flags}, 8'h00);
    chk("rst_valid", {7'd0, cond_valid}, 8'h00);

    // Full-mask capture
    capture(5'b10101);
    chk("cap_all", {3'b000, flags}, 8'h15);
    chk("lcarry_1", {7'd0, lcarry}, 8'h01);

    // Partial mask and zero mask
    capture(5'b11111);
    idle(); alu_active = 1'b1; mask = 5'b00100; alu = 5'b00000; tick();
    chk("cap_mask_z", {3'b000, flags}, 8'h1B);
    idle(); alu_active = 1'b1; mask = 5'b00000; alu = 5'b00000; tick();
    chk("cap_mask_0", {3'b000, flags}, 8'h1B);

    // Bus drive, then load beating a same-cycle capture
    capture(5'b01010);
    idle(); assert_n = 1'b0;
    #1 chk("bus_drive", main_bus, 8'h0A);
    idle(); load_n = 1'b0; tb_bus_en = 1'b1; tb_bus_val = 8'hF3;
    alu_active = 1'b1; mask = 5'b11111; alu = 5'b00000;
    tick();
    chk("load_wins", {3'b000, flags}, 8'h13);

    // Assert and Load together: drive wins, load suppressed
    capture(5'b00001);
    idle(); assert_n = 1'b0; load_n = 1'b0;
    #1 chk("bus_both", main_bus, 8'h01);
    tick();
    chk("load_supp", {3'b000, flags}, 8'h01);

    // Conditions evaluated on forwarded next flags
    capture(5'b00000);
    idle(); alu_active = 1'b1; mask = 5'b11111; alu = 5'b00100;
    cond_eval = 1'b1; cond_sel = 4'h1; tick();
    chk("eq_valid", {7'd0, cond_valid}, 8'h01);
    chk("eq_fwd", {7'd0, cond_true}, 8'h01);
    cond_sel = 4'h9; tick();
    chk("ne_fwd", {7'd0, cond_true}, 8'h00);
    alu = 5'b00010; cond_sel = 4'h6; tick();
    chk("lt_fwd", {7'd0, cond_true}, 8'h01);
    idle(); tick();
    chk("hold_valid", {7'd0, cond_valid}, 8'h00);
    chk("hold_true", {7'd0, cond_true}, 8'h01);

    // Reset cancels a pending evaluation
    capture(5'b10110);
    idle(); cond_eval = 1'b1; cond_sel = 4'h0; tick();
    reset = 1'b1; assert_n = 1'b0; tb_bus_en = 1'b1; tb_bus_val = 8'hC3;
    tick();
    chk("rst_cancel_v", {7'd0, cond_valid}, 8'h00);
    chk("rst_cancel_t", {7'd0, cond_true}, 8'h00);
    chk("rst_flags2", {3'b000, flags}, 8'h00);
    #1 chk("bus_rel_reset2", main_bus, 8'hC3);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      reset      = ($urandom_range(0, 39) == 0);
      alu        = 5'($urandom);
      alu_active = $urandom_range(0, 1) == 1;
      mask       = 5'($urandom);
      assert_n   = $urandom_range(0, 3) != 0;
      load_n     = $urandom_range(0, 3) != 0;
      cond_eval  = $urandom_range(0, 2) != 0;
      cond_sel   = 4'($urandom);
      tb_bus_val = 8'($urandom);
      if (!assert_n) tb_bus_en = reset;
      else if (!load_n) tb_bus_en = 1'b1;
      else tb_bus_en = $urandom_range(0, 1) == 1;
      #1;
      if (!assert_n && !reset) chk("rnd_bus_drive", main_bus, {3'b000, m_flags});
      else if (!assert_n) chk("rnd_bus_rel", main_bus, tb_bus_val);
      tick();
    end

    idle();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
